t03_inst_encoder: RTL and testbench
===================================

# t03_inst_encoder

Packs decoded RISC-V RV32I instruction fields (format, opcode, registers, funct bits, full 32-bit immediate) back into a 32-bit instruction word. It is the inverse of the immediate generator in the decode stage. It sits between the team's test/boot loader and the instruction memory write port, and produces sequential word addresses alongside each encoded word. Each immediate is checked for range and alignment against its format, and a registered error flag marks any violation.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, address loaded into the address counter at reset.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; loads `base_addr` into the address counter.
- base_addr  input  32  start address; must be word-aligned, bits [1:0] ignored.
- in_valid  input  1  input fields valid.
- in_ready  output  1  encoder can accept the input fields this cycle.
- fmt  input  3  format select: R=0, I=1, S=2, B=3, U=4, J=5; codes 6–7 are illegal.
- opcode  input  7  opcode field, passed through to bits [6:0].
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field.
- imm  input  32  sign-extended immediate as the decoder would produce it.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer accepts the encoded word.
- out_instr  output  32  encoded instruction.
- out_addr  output  32  word address for `out_instr`.
- out_err  output  1  immediate or format violation for this word.
- err_count  output  8  saturating count of errored words that were accepted downstream.

## Operation
- Input is accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is a single-entry pipeline register with a full-throughput pass-through.
- Packing per format:
  - R: `{funct7, rs2, rs1, funct3, rd, opcode}`; `imm` is ignored.
  - I: `{imm[11:0], rs1, funct3, rd, opcode}`.
  - S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`.
  - B: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`.
  - U: `{imm[31:12], rd, opcode}`.
  - J: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}`.
- Error rules (`out_err = 1`). The word is still packed from the truncated bits in every case.
  - I/S: `imm` is outside −2048…2047, i.e. `imm[31:11]` is not all-equal.
  - B: `imm[31:12]` is not all-equal, or `imm[0] = 1`.
  - J: `imm[31:20]` is not all-equal, or `imm[0] = 1`.
  - U: `imm[11:0] != 0`.
  - fmt 6–7: `out_instr = 0` and `out_err = 1`.
- Address counter:
  - Holds the address of the next word to emit.
  - On output handshake (`out_valid && out_ready`) it advances by 4, wrapping modulo 2^32.
  - `start` loads `{base_addr[31:2], 2'b00}`. If `start` and the output handshake occur in the same cycle, `start` wins: the counter loads `base_addr`, not `base_addr + 4`.
  - `out_addr` is latched from the counter when the input is captured.
- `err_count` increments on the output handshake when `out_err = 1`, and saturates at 255. `start` clears it; if `start` and an errored handshake coincide, the result is 0.

## Timing
- Latency: one cycle. Fields captured on edge N appear on `out_*` after edge N.
- Under stall (`out_valid && !out_ready`), all `out_*` hold stable and `in_ready = 0`.
- Reset (asynchronous, takes effect at any time, including mid-stall) forces:
  - `out_valid = 0`
  - `out_instr = 0`
  - `out_addr = RESET_ADDR`
  - `out_err = 0`
  - `err_count = 0`
  - address counter = `RESET_ADDR`
  
  The pending word is dropped, not replayed.
- `in_ready` is combinational from `out_valid` and `out_ready`. No other path runs combinationally from input to output.
- `start` during a stall does not alter the held `out_addr`; it affects only subsequently captured words.

## Structure
- Shared package `t03_pkg`:
  - `fmt_t` enum (R, I, S, B, U, J).
  - Opcode constants: OP_IMM 7'b0010011, LOAD 7'b0000011, STORE 7'b0100011, BRANCH 7'b1100011, JAL 7'b1101111, JALR 7'b1100111, LUI 7'b0110111, AUIPC 7'b0010111.
- Sub-module `t03_imm_pack`: purely combinational. Inputs: fmt, imm, and the register/funct fields. Outputs: packed word and err. The top-level block holds the handshake register, the address counter and the error counter.

## Test plan
- After reset, `start` with `base_addr` 0x100, then I-type `addi x1,x0,5` (opcode 0x13, imm 5) → `out_instr` 0x00500093, `out_addr` 0x100, `out_err` 0.
- Back-to-back S-type `sw x2,8(x1)`, then B-type `beq x0,x0,-4` → 0x0020A423 @0x104, then 0xFE000EE3 @0x108, one word per cycle.
- U-type `lui x5` (imm 0x12345000) → 0x123452B7; J-type `jal x1` with imm 0x800 → 0x001000EF.
- Error cases:
  - I-type with imm 2048 → `out_err` 1.
  - B-type with imm 3 → `out_err` 1.
  - fmt 7 → `out_instr` 0 and `out_err` 1.
  - `err_count` reads 3 after all three handshakes.
- Hold `out_ready` low for 5 cycles while `in_valid` stays high → `in_ready` 0 and `out_*` stable; release → next word appears the following cycle at the correct address.
- Assert `nrst` low mid-stall → all outputs are at their reset values immediately; after release the first word's `out_addr` equals `RESET_ADDR`.

Source files
------------

// File: rtl/t03_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package t03_pkg;

  // Instruction format select; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // True when imm[31:msb] are all equal, i.e. the value survives truncation
  // to msb+1 bits followed by sign extension.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << msb;
    return ((imm & mask) == 32'd0) || ((imm & mask) == mask);
  endfunction

endpackage

// File: rtl/t03_imm_pack.sv
// Combinational packer: scatters register, funct and immediate fields into
// an RV32I word and flags immediates that do not fit or are misaligned.
module t03_imm_pack
  import t03_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  // Format-dependent packing; the word is built from truncated bits even
  // when the immediate is flagged, only illegal formats produce zero.
  always_comb begin
    instr_o = 32'd0;
    err_o   = 1'b0;
    case (fmt_t'(fmt_i))
      FMT_R: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        err_o   = !fits_signed(imm_i, 11);
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        err_o   = !fits_signed(imm_i, 11);
      end
      FMT_B: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        err_o   = !fits_signed(imm_i, 12) || imm_i[0];
      end
      FMT_U: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        err_o   = (imm_i[11:0] != 12'd0);
      end
      FMT_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        err_o   = !fits_signed(imm_i, 20) || imm_i[0];
      end
      default: begin
        instr_o = 32'd0;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/t03_inst_encoder.sv
// Instruction encoder top: single-entry output register with pass-through
// ready, sequential word address generation and a saturating error counter.
module t03_inst_encoder
  import t03_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  logic [31:0] pack_instr;
  logic        pack_err;

  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_addr_q;
  logic        out_err_q;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic accept;
  logic out_hs;

  t03_imm_pack u_pack (
    .fmt_i    (fmt),
    .opcode_i (opcode),
    .rd_i     (rd),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .imm_i    (imm),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // Next counter value; start beats the handshake increment. A word captured
  // in the same cycle as the previous word leaves takes the advanced address.
  always_comb begin
    addr_d = addr_q;
    if (start) begin
      addr_d = base_addr & 32'hFFFF_FFFC;
    end else if (out_hs) begin
      addr_d = addr_q + 32'd4;
    end
  end

  // Error counter next value: start clears (even against an errored
  // handshake), otherwise count errored handshakes up to 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (start) begin
      err_cnt_d = 8'd0;
    end else if (out_hs && out_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Output register: capture on accept, drop valid when drained, hold on stall.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_addr_q  <= RESET_ADDR;
      out_err_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_instr_q <= pack_instr;
      out_addr_q  <= addr_d;
      out_err_q   <= pack_err;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Address and error counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q    <= RESET_ADDR;
      err_cnt_q <= 8'd0;
    end else begin
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_t03_inst_encoder.sv
// Self-checking bench for t03_inst_encoder: expected words are queued when
// the bench hands fields to the encoder and compared when the word leaves.
module tb_t03_inst_encoder;
  import t03_pkg::*;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  t03_inst_encoder #(.RESET_ADDR(RST_ADDR)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_addr;
  logic        rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference encoder written from the field layout, ranges checked numerically.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    logic        e;
    longint      si;
    si = longint'($signed(im));
    w  = 32'd0;
    e  = 1'b0;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, op};
      3'd1: begin
        w = {im[11:0], s1, f3, d, op};
        e = (si < -2048) || (si > 2047);
      end
      3'd2: begin
        w = {im[11:5], s2, s1, f3, im[4:0], op};
        e = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = (si < -4096) || (si > 4095) || im[0];
      end
      3'd4: begin
        w = {im[31:12], d, op};
        e = (im[11:0] != 12'd0);
      end
      3'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = (si < -1048576) || (si > 1048575) || im[0];
      end
      default: begin
        w = 32'd0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  // Output side: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", out_instr, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr", out_instr, e.instr);
        chk("addr", out_addr, e.addr);
        chk("err", 32'(out_err), 32'(e.err));
      end
    end
  end

  // Random backpressure during the random phase.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b);
    start     = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    exp_addr = b & 32'hFFFF_FFFC;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Present one word, wait (bounded) for in_ready, queue its expectation.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] e_instr, input logic e_err, output int waits);
    bit   got;
    exp_t e;
    set_fields(f, op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    waits    = 0;
    got      = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else          waits++;
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      e.instr  = e_instr;
      e.addr   = exp_addr;
      e.err    = e_err;
      exp_q.push_back(e);
      exp_addr = exp_addr + 32'd4;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_m(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
    logic [32:0] m;
    int          w;
    m = model(f, op, d, s1, s2, f3, f7, im);
    send(f, op, d, s1, s2, f3, f7, im, m[31:0], m[32], w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [31:0] a_addr;
    logic [31:0] rimm;
    logic [2:0]  rf;

    nrst = 1'b0; start = 1'b0; base_addr = 32'd0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    exp_addr = RST_ADDR;
    idle(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, RST_ADDR);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    nrst = 1'b1;
    idle(1);

    // Directed words from the reference program.
    do_start(32'h0000_0100);
    send(3'(FMT_I), OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0, w);
    send(3'(FMT_S), OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0, w);
    chk("b2b_sw_wait", 32'(w), 32'd0);
    send(3'(FMT_B), OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, w);
    chk("b2b_beq_wait", 32'(w), 32'd0);
    send(3'(FMT_U), OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, w);
    send(3'(FMT_J), OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0, w);

    // Error words: I out of range, misaligned branch, illegal format.
    send(3'(FMT_I), OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b1, w);
    send(3'(FMT_B), OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b1, w);
    send(3'd7, OP_IMM, 5'd1, 5'd2, 5'd3, 3'd1, 7'd5, 32'd7, 32'h0000_0000, 1'b1, w);
    idle(3);
    chk("err_count_3", 32'(err_count), 32'd3);

    // Stall: A held for 5 cycles while B is offered.
    out_ready = 1'b0;
    a_addr = exp_addr;
    send(3'(FMT_I), OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0193, 1'b0, w);
    set_fields(3'(FMT_I), OP_LOAD, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_instr", out_instr, 32'hFFF0_0193);
      chk("stall_addr", out_addr, a_addr);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'(FMT_I), OP_LOAD, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4, 32'h0041_2203, 1'b0, w);
    chk("release_wait", 32'(w), 32'd0);
    idle(2);

    // Random words under random backpressure; base low bits are dropped.
    do_start(32'h0000_0203);
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rf   = 3'($urandom_range(0, 7));
      rimm = $urandom_range(0, 1) ? $urandom : 32'($signed(12'($urandom)));
      send_m(rf, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), rimm);
    end
    rnd_ready = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(4);

    // Saturation and address wrap across 2^32.
    do_start(32'hFFFF_FFF8);
    for (int i = 0; i < 258; i++) begin
      send(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1, w);
    end
    idle(3);
    chk("err_count_sat", 32'(err_count), 32'd255);

    // Start coincides with an errored handshake: counter loads base, count clears.
    out_ready = 1'b0;
    send(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1, w);
    out_ready = 1'b1;
    do_start(32'h0000_0400);
    chk("start_clear_cnt", 32'(err_count), 32'd0);
    send(3'(FMT_S), OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4096, 32'h0020_A023, 1'b1, w);
    idle(2);
    chk("err_count_1", 32'(err_count), 32'd1);

    // Reset in the middle of a stall drops the pending word.
    out_ready = 1'b0;
    send(3'(FMT_R), 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3, 1'b0, w);
    set_fields(3'(FMT_I), OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    chk("mid_rst_addr", out_addr, RST_ADDR);
    chk("mid_rst_err", 32'(out_err), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    exp_addr = RST_ADDR;
    idle(2);
    nrst = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(3'(FMT_I), OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0, w);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
